// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 Hz VGA timing definitions, used by vga_sync and the pixel/text generators.
package vga_sync_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int TICK_DIV  = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync to the colour mux and pixel generators.
interface vga_sync_if;
    import vga_sync_pkg::coord_t;

    logic   p_tick;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;

    modport master (output p_tick, hsync, vsync, video_on, pixel_x, pixel_y);
    modport slave  (input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y);

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// Divide-by-TICK_DIV pixel enable: p_tick is a registered one-clk pulse every TICK_DIV clks.
module vga_sync_pixel_tick_gen #(
    parameter int TICK_DIV = vga_sync_pkg::TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        p_tick_d = (div_q == DIV_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            p_tick_q <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters advanced by p_tick, registered hsync/vsync, video_on decode.
module vga_sync
    import vga_sync_pkg::coord_t;
    import vga_sync_pkg::in_window;
#(
    parameter int TICK_DIV  = vga_sync_pkg::TICK_DIV,
    parameter int H_DISPLAY = vga_sync_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_sync_pkg::H_FRONT,
    parameter int H_SYNC    = vga_sync_pkg::H_SYNC,
    parameter int H_BACK    = vga_sync_pkg::H_BACK,
    parameter int V_DISPLAY = vga_sync_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_sync_pkg::V_FRONT,
    parameter int V_SYNC    = vga_sync_pkg::V_SYNC,
    parameter int V_BACK    = vga_sync_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vif
);

    localparam int     H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int     HS_START = H_DISPLAY + H_FRONT;
    localparam int     HS_END   = HS_START + H_SYNC - 1;
    localparam int     VS_START = V_DISPLAY + V_FRONT;
    localparam int     VS_END   = VS_START + V_SYNC - 1;
    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);

    logic   p_tick;
    coord_t x_q, x_d, y_q, y_d;
    logic   hsync_q, hsync_d, vsync_q, vsync_d;

    vga_sync_pixel_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
        // Syncs decode the next-state counters so the registered pulses line up with pixel_x/pixel_y.
        hsync_d = !in_window(x_d, HS_START, HS_END);
        vsync_d = !in_window(y_d, VS_START, VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vif.p_tick   = p_tick;
    assign vif.hsync    = hsync_q;
    assign vif.vsync    = vsync_q;
    assign vif.pixel_x  = x_q;
    assign vif.pixel_y  = y_q;
    assign vif.video_on = (int'(x_q) < H_DISPLAY) && (int'(y_q) < V_DISPLAY);

endmodule
